// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter and write sequencer for one shared register
// Optional feature macro: ARB_TIMEOUT_EN (forces release after MAX_HOLD locked cycles).
module reg_share_arb #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;

  logic [PW-1:0] sel_idle;
  logic [PW-1:0] sel_own;
  logic [PW-1:0] nxt_ptr;
  logic [N-1:0]  cand;
  logic [W-1:0]  wsel;
  logic          any_idle;
  logic          any_own;
  logic          wr;
  logic          rel;
  logic          timeout;

  // Reject configurations the arbiter cannot support.
  if (N < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("reg_share_arb: N must be >= 2 and MAX_HOLD >= 1");
  end

  // First requester with a bit set, scanning upward from start and wrapping at N-1.
  function automatic logic [PW-1:0] pick(input logic [N-1:0] r, input logic [PW-1:0] start);
    logic [PW-1:0] idx;
    logic          found;
    pick  = start;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;

  // The current OWN cycle is the MAX_HOLD-th for this owner.
  assign timeout = (hold_cnt == HW'(MAX_HOLD - 1));

  // Count consecutive OWN cycles of one owner; any release or idle restarts the count.
  always_ff @(posedge clk) begin
    if (!rst || state != S_OWN || rel) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-grant selection for both states, plus the owner's write and release decision.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == PW'(i)) begin
        wsel = wdata[i*W +: W];
      end
    end
    any_idle = |req;
    sel_idle = pick(req, ptr);
    wr       = req[owner];
    rel      = !req[owner] || !lock[owner] || timeout;
    nxt_ptr  = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
    // A still-locked owner forced out by the timeout may not win its own handoff.
    cand     = req;
    if (lock[owner]) begin
      cand[owner] = 1'b0;
    end
    any_own  = |cand;
    sel_own  = pick(cand, nxt_ptr);
  end

  // Arbitration FSM: registered grant, owner and busy, plus the shared register write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      gnt   <= '0;
      q     <= '0;
      owner <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_idle) begin
            state <= S_OWN;
            busy  <= 1'b1;
            owner <= sel_idle;
            gnt   <= onehot(sel_idle);
          end
        end
        S_OWN: begin
          if (wr) begin
            q <= wsel;
          end
          if (rel) begin
            ptr <= nxt_ptr;
            if (any_own) begin
              owner <= sel_own;
              gnt   <= onehot(sel_own);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              gnt   <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - randomized and directed checks of reg_share_arb against a behavioural model
module tb_reg_share_arb;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [1:0]     owner;
  logic           busy;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  bit           m_busy  = 1'b0;
  int           m_owner = 0;
  int           m_ptr   = 0;
  int           m_hold  = 0;
  logic [W-1:0] m_q     = '0;

  logic [W-1:0] wd;

  reg_share_arb #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One clock edge of the arbiter as described: grant from IDLE, or write/release in OWN.
  task automatic model_step();
    int  o;
    int  s;
    bit  to;
    logic [N-1:0] others;
    if (!rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_q = '0;
    end else if (!m_busy) begin
      s = search(req, m_ptr);
      if (s >= 0) begin
        m_busy = 1; m_owner = s; m_hold = 0;
      end
    end else begin
      o = m_owner;
      if (req[o]) m_q = wdata[o*W +: W];
      m_hold++;
`ifdef ARB_TIMEOUT_EN
      to = (m_hold >= MAX_HOLD);
`else
      to = 1'b0;
`endif
      if (!req[o] || !lock[o] || to) begin
        m_ptr     = (o + 1) % N;
        others    = req;
        others[o] = 1'b0;
        s = search(others, m_ptr);
        if (s < 0 && req[o] && !lock[o]) s = o;
        if (s >= 0) begin
          m_owner = s; m_hold = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("q", 32'(q), 32'(m_q));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic set_wd(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic go_idle();
    req  = '0;
    lock = '0;
    cycle();
    cycle();
  endtask

  initial begin
    rst = 1'b0; req = '1; lock = '0; wdata = '0;

    // Reset held with all requests high
    cycle();
    cycle();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Fairness: all requesting, no lock
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_wd(i, 8'(8'h10 + i));
    cycle();
    chk("first_gnt", 32'(gnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fair_q", 32'(q), 32'h10 + 32'(k));
      chk("fair_gnt", 32'(gnt), 32'd1 << ((k + 1) % N));
    end
    go_idle();

`ifndef ARB_TIMEOUT_EN
    // Locked requester 2 writes every cycle, then handoff wraps to 0 and 1
    req = 4'b0100; lock = 4'b0100;
    cycle();
    chk("lock_gnt", 32'(gnt), 32'd4);
    for (int k = 0; k < 5; k++) begin
      wd = 8'($urandom_range(0, 255));
      set_wd(2, wd);
      cycle();
      chk("lock_q", 32'(q), 32'(wd));
      chk("lock_hold", 32'(gnt), 32'd4);
    end
    req = 4'b0011; lock = '0;
    set_wd(0, 8'h5A);
    set_wd(1, 8'h5B);
    cycle();
    chk("lock_rel_gnt", 32'(gnt), 32'd1);
    chk("lock_rel_q", 32'(q), 32'(wd));
    cycle();
    chk("lock_next_q", 32'(q), 32'h5A);
    chk("lock_next_gnt", 32'(gnt), 32'd2);
    go_idle();
`else
    // Timeout: locked requester 1 holds exactly MAX_HOLD cycles, then 0 takes over
    req = 4'b0010; lock = 4'b0010;
    cycle();
    chk("to_gnt", 32'(gnt), 32'd2);
    req = 4'b0011;
    cycle();
    chk("to_hold1", 32'(gnt), 32'd2);
    cycle();
    chk("to_hold2", 32'(gnt), 32'd2);
    cycle();
    chk("to_move", 32'(gnt), 32'd1);
    go_idle();
`endif

    // Dropped request: grant to 3 with no write, then search restarts at 0
    req = 4'b1000; lock = '0;
    set_wd(3, 8'hC3);
    cycle();
    chk("drop_gnt", 32'(gnt), 32'd8);
    req = '0;
    cycle();
    chk("drop_idle_gnt", 32'(gnt), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_q_kept", 32'(q == 8'hC3), 32'd0);
    req = 4'b1111;
    cycle();
    chk("drop_next", 32'(gnt), 32'd1);
    go_idle();

    // Mid-burst reset overrides the write
    req = 4'b0001; lock = 4'b0001;
    set_wd(0, 8'h55);
    cycle();
    cycle();
    chk("burst_q", 32'(q), 32'h55);
    set_wd(0, 8'hAA);
    rst = 1'b0;
    cycle();
    chk("mrst_q", 32'(q), 32'd0);
    chk("mrst_gnt", 32'(gnt), 32'd0);
    rst = 1'b1;
    req = '0; lock = '0;
    cycle();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 63) != 0);
      req   = N'($urandom);
      lock  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      wdata = ($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
